// File: rtl/mips_mem_responder_if.sv
// mips_mem_responder_if: core memory bus plus boot-loader stream and core control
interface mips_mem_responder_if #(parameter int WIDTH = 8);
  logic             memread;
  logic             memwrite;
  logic [WIDTH-1:0] adr;
  logic [WIDTH-1:0] writedata;
  logic [WIDTH-1:0] memdata;
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_last;
  logic             load_ready;
  logic             cpu_rst;
  logic             running;
  modport master (
    output memread, memwrite, adr, writedata, load_valid, load_data, load_last,
    input  memdata, load_ready, cpu_rst, running
  );
  modport slave (
    input  memread, memwrite, adr, writedata, load_valid, load_data, load_last,
    output memdata, load_ready, cpu_rst, running
  );
endinterface

// File: rtl/mips_mem_responder.sv
// mips_mem_responder: byte memory for the multicycle mips core with a boot-loader that holds the core in reset
module mips_mem_responder #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 256,
  parameter int HOLD_CYCLES = 2
) (
  input logic clk,
  input logic rst,
  mips_mem_responder_if.slave bus
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  typedef enum logic [1:0] {LOAD, HOLD, RUN} state_t;
  state_t           state;
  logic [AW-1:0]    load_ptr;
  logic [AW-1:0]    idx;
  logic [HW-1:0]    hold_cnt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  assign idx = bus.adr[AW-1:0];
  // Single write port shared by the loader (LOAD) and the core (RUN)
  always_comb begin
    we    = state == LOAD ? bus.load_valid : (state == RUN) && bus.memwrite;
    waddr = state == LOAD ? load_ptr : idx;
    wdata = state == LOAD ? bus.load_data : bus.writedata;
  end
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // Read is combinational so the core sees pre-write data during a same-cycle write
  assign bus.memdata = (bus.running && bus.memread) ? mem[idx] : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= LOAD;
      load_ptr       <= '0;
      hold_cnt       <= '0;
      bus.cpu_rst    <= 1'b1;
      bus.running    <= 1'b0;
      bus.load_ready <= 1'b1;
    end else begin
      case (state)
        LOAD: if (bus.load_valid) begin
          load_ptr <= load_ptr + 1'b1;
          if (bus.load_last || load_ptr == AW'(DEPTH - 1)) begin
            state          <= HOLD;
            hold_cnt       <= '0;
            bus.load_ready <= 1'b0;
          end
        end
        HOLD: if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
          state       <= RUN;
          bus.cpu_rst <= 1'b0;
          bus.running <= 1'b1;
        end else begin
          hold_cnt <= hold_cnt + 1'b1;
        end
        RUN: ;
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_mem_responder.sv
// tb_mips_mem_responder: directed and random checks of loader, hold timing and core memory traffic
module tb_mips_mem_responder;
  localparam int W = 8, D = 256, H = 2;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  mips_mem_responder_if #(.WIDTH(W)) bus ();
  mips_mem_responder #(.WIDTH(W), .DEPTH(D), .HOLD_CYCLES(H)) dut (.clk(clk), .rst(rst), .bus(bus));
  int errors = 0, checks = 0;
  logic [7:0] ref_mem [D];
  logic       ref_ok  [D];
  int ptr;
  logic done;
  logic [7:0] a, d, old;
  logic rd, wr;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    bus.memread = 0; bus.memwrite = 0; bus.adr = 0; bus.writedata = 0;
    bus.load_valid = 0; bus.load_data = 0; bus.load_last = 0;
  endtask
  task automatic do_reset;
    rst = 1;
    tick;
    rst = 0;
    ptr = 0;
    chk("rst_cpu_rst", bus.cpu_rst, 1);
    chk("rst_running", bus.running, 0);
    chk("rst_load_ready", bus.load_ready, 1);
  endtask
  task automatic load_byte(input logic [7:0] b, input logic last, output logic fin);
    bus.load_valid = 1; bus.load_data = b; bus.load_last = last;
    chk("load_ready_during_load", bus.load_ready, 1);
    tick;
    ref_mem[ptr] = b; ref_ok[ptr] = 1; ptr++;
    fin = last || ptr == D;
    bus.load_valid = 0; bus.load_last = 0;
  endtask
  task automatic wait_run;
    int n = 0;
    while (!bus.running && n < 20) begin
      chk("hold_cpu_rst", bus.cpu_rst, 1);
      chk("hold_load_ready", bus.load_ready, 0);
      tick;
      n++;
    end
    chk("hold_length", 16'(n), 16'(H));
    chk("run_cpu_rst", bus.cpu_rst, 0);
    chk("run_load_ready", bus.load_ready, 0);
  endtask
  task automatic read_chk(input logic [7:0] ad);
    bus.memread = 1; bus.adr = ad;
    #1;
    chk($sformatf("read_%0h", ad), bus.memdata, ref_mem[ad]);
    bus.memread = 0;
  endtask
  initial begin
    for (int i = 0; i < D; i++) ref_ok[i] = 0;
    idle;
    rst = 1;
    tick;
    do_reset;
    bus.memread = 1;
    #1;
    chk("memdata_in_load", bus.memdata, 0);
    bus.memread = 0;
    // Basic 4-byte program with load_last
    load_byte(8'h20, 0, done);
    load_byte(8'h02, 0, done);
    load_byte(8'h00, 0, done);
    load_byte(8'h05, 1, done);
    chk("short_load_done", 16'(done), 1);
    wait_run;
    for (int i = 0; i < 4; i++) read_chk(8'(i));
    // Full 256-byte load with random gaps and ignored core writes
    do_reset;
    bus.memwrite = 1;
    done = 0;
    for (int k = 0; k < 2000 && !done; k++) begin
      bus.adr = 8'($urandom); bus.writedata = 8'($urandom);
      if ($urandom_range(3) == 0) tick;
      else load_byte(8'($urandom), 0, done);
    end
    chk("full_load_done", 16'(done), 1);
    bus.memwrite = 0;
    bus.load_valid = 1; bus.load_data = 8'hEE;
    wait_run;
    bus.load_valid = 0;
    for (int i = 0; i < D; i++) read_chk(8'(i));
    // Same-cycle read sees old data, next cycle sees new
    old = ref_mem[8'h10];
    bus.memwrite = 1; bus.memread = 1; bus.adr = 8'h10; bus.writedata = 8'hA5;
    #1;
    chk("rw_same_cycle_old", bus.memdata, old);
    tick;
    ref_mem[8'h10] = 8'hA5;
    bus.memwrite = 0;
    #1;
    chk("read_after_write", bus.memdata, 8'hA5);
    bus.memread = 0;
    #1;
    chk("no_read_zero", bus.memdata, 0);
    // Random core traffic against the reference array
    for (int i = 0; i < 300; i++) begin
      a = 8'($urandom); d = 8'($urandom);
      rd = 1'($urandom); wr = 1'($urandom);
      bus.adr = a; bus.writedata = d; bus.memread = rd; bus.memwrite = wr;
      #1;
      chk("rand_memdata", bus.memdata, rd ? ref_mem[a] : 8'h00);
      tick;
      if (wr) ref_mem[a] = d;
    end
    idle;
    // Reset mid-run, gapped reload with a core write to address 3 that must be ignored
    do_reset;
    bus.memwrite = 1; bus.adr = 8'h03; bus.writedata = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      chk("gap_load_ready", bus.load_ready, 1);
      bus.load_valid = (k == 0 || k == 3);
      bus.load_last = (k == 3);
      bus.load_data = 8'($urandom);
      d = bus.load_data;
      tick;
      if (k == 0 || k == 3) begin
        ref_mem[ptr] = d; ptr++;
      end
    end
    chk("gap_ptr_model", 16'(ptr), 2);
    idle;
    wait_run;
    for (int i = 0; i < 4; i++) read_chk(8'(i));
    read_chk(8'h10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mips_mem_responder.md
Name: mips_mem_responder

Overview:
- Memory-side responder for the 8-bit multicycle mips core. It serves the core's memread/memwrite/adr/writedata requests and returns memdata.
- Contains a boot-loader FSM. After reset it holds the core in reset, fills memory from a byte stream, then releases the core.
- Sits beside mips at the top level. Its memdata output drives mips memdata. Its cpu_rst output drives mips rst.

Parameters:
- WIDTH, 8, data and address width in bits.
- DEPTH, 256, number of bytes stored; must be ≤ 2**WIDTH and a power of two.
- HOLD_CYCLES, 2, cycles cpu_rst stays high after loading completes; must be ≥ 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-high.
- memread  input  1  core read strobe.
- memwrite  input  1  core write strobe.
- adr  input  WIDTH  core byte address.
- writedata  input  WIDTH  core write data.
- memdata  output  WIDTH  read data to the core.
- load_valid  input  1  loader byte valid.
- load_data  input  WIDTH  loader byte.
- load_last  input  1  marks the final loader byte; qualified by load_valid.
- load_ready  output  1  loader may transfer this cycle.
- cpu_rst  output  1  reset to the core, active-high.
- running  output  1  high while the core is being served.

Behaviour:
- Storage: DEPTH x WIDTH array. Index = adr modulo DEPTH (low log2(DEPTH) bits). The array is not cleared by rst.
- FSM states: LOAD, HOLD, RUN.
- Reset values (rst=1 at a rising edge, from any state including mid-load or RUN):
  - state=LOAD, load_ptr=0, hold_cnt=0.
  - cpu_rst=1, running=0, load_ready=1.
- LOAD:
  - load_ready=1.
  - Each edge with load_valid=1 writes load_data to mem[load_ptr] and increments load_ptr.
  - Go to HOLD after the write if load_last=1, or if load_ptr was DEPTH-1 (wrap-around ends the load; the pointer never writes index 0 twice).
  - Edges with load_valid=0 change nothing.
  - Core memread/memwrite are ignored; no array write comes from the core.
- HOLD:
  - load_ready=0; load_valid is ignored.
  - hold_cnt counts 0..HOLD_CYCLES-1, then state goes to RUN.
  - cpu_rst=1 for exactly HOLD_CYCLES edges after the last load byte.
- RUN:
  - cpu_rst=0, running=1, load_ready=0.
  - A new load requires rst.
- Outputs are registered decodes of state:
  - cpu_rst=1 in LOAD and HOLD.
  - running=1 only in RUN.
  - load_ready=1 only in LOAD.
- Core reads (RUN only):
  - memdata is combinational: mem[adr] when memread=1, else 0.
  - Zero cycles of latency, so the core latches it at the same edge it asserts memread.
  - Outside RUN, memdata=0.
- Core writes (RUN only): at an edge with memwrite=1, mem[adr] ← writedata.
- Simultaneous memread and memwrite in RUN:
  - memdata shows the pre-write contents during that cycle.
  - The write commits at the edge.
  - A read in the following cycle returns the new value.
- Address ≥ DEPTH (when DEPTH < 2**WIDTH) aliases modulo DEPTH. No error is flagged.
- Undefined/X on memread or memwrite in RUN is a verification failure. The block does not filter it.

Test Plan:
- Reset then stream 4 bytes 0x20,0x02,0x00,0x05 with load_last on the 4th.
  - load_ready=1 for all 4 transfers.
  - mem[0..3] holds those bytes.
  - cpu_rst stays 1 for 2 more edges, then 0; running rises the same cycle cpu_rst falls.
- Load with gaps (load_valid toggling 1,0,0,1) → load_ptr advances only on valid cycles; bytes land at 0 and 1.
- Stream 256 bytes with no load_last → auto-transition to HOLD after index 255; mem[0] is unchanged from the first byte.
- RUN, memwrite=1, adr=0x10, writedata=0xA5:
  - Next cycle memread=1, adr=0x10 → memdata=0xA5.
  - Same cycle as the write with memread=1 → memdata shows the old value.
- RUN, memread=0 → memdata=0x00. During LOAD, memwrite=1 at adr=0x03 with 0xFF → mem[3] unchanged.
- Assert rst mid-RUN → next cycle cpu_rst=1, load_ready=1, load_ptr=0, memory contents preserved; reload overwrites from address 0.
